// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/LSB request-response bus plus the byte-wide RAM port.
interface mem_arbiter_if;
    // icache fetch channel
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;

    // load/store channel
    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    // control and RAM port
    logic        clr;
    logic        io_buffer_full;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    // Arbiter side: drives responses and the RAM port
    modport master (
        input  ic_req, ic_addr, ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        input  clr, io_buffer_full, mem_din,
        output ic_valid, ic_data, ls_done, ls_rdata, mem_a, mem_dout, mem_wr
    );

    // Client/RAM side: drives requests and read data
    modport slave (
        output ic_req, ic_addr, ls_req, ls_wr, ls_addr, ls_size, ls_wdata,
        output clr, io_buffer_full, mem_din,
        input  ic_valid, ic_data, ls_done, ls_rdata, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM between icache fetches and LSB loads/stores.
// Bytes move one per cycle; responses are one-cycle pulses; rdy low freezes everything.
// Optional MEM_ARB_IO_STALL_EN: hold store bytes to the I/O region while the UART is full.
module mem_arbiter #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy,
    mem_arbiter_if.master bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IFETCH = 2'd1,
        S_LOAD   = 2'd2,
        S_STORE  = 2'd3
    } state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [CW-1:0] r_nbytes, w_nbytes;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] r_wdata, w_wdata;
    logic [DW-1:0] r_buf, w_buf;
    logic          r_last_ls, w_last_ls;

    logic          r_ic_valid, w_ic_valid;
    logic [DW-1:0] r_ic_data, w_ic_data;
    logic          r_ls_done, w_ls_done;
    logic [DW-1:0] r_ls_rdata, w_ls_rdata;
    logic [AW-1:0] r_mem_a, w_mem_a;
    logic [BW-1:0] r_mem_dout, w_mem_dout;
    logic          r_mem_wr, w_mem_wr;

    logic [AW-1:0] w_byte_a;
    logic [DW-1:0] w_cap_buf;
    logic [BW-1:0] w_wbyte;
    logic [CW-1:0] w_req_nbytes;
    logic          w_ic_ok;
    logic          w_ls_win;
    logic          w_stall;

    assign w_byte_a = r_addr + AW'(r_cnt);
    assign w_ic_ok  = bus.ic_req & ~bus.clr;
    assign w_ls_win = bus.ls_req & ~(w_ic_ok & r_last_ls);

`ifdef MEM_ARB_IO_STALL_EN
    assign w_stall = (w_byte_a[17:16] == IO_SEL) & bus.io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = &{1'b0, bus.io_buffer_full, IO_SEL};
    assign w_stall     = 1'b0;
`endif

    // Byte count of the incoming LSB request
    always_comb begin
        case (bus.ls_size)
            2'b00:   w_req_nbytes = CW'(1);
            2'b01:   w_req_nbytes = CW'(2);
            default: w_req_nbytes = CW'(4);
        endcase
    end

    // Lane steering: read byte r_cnt-1 lands in its lane, store byte r_cnt is selected
    always_comb begin
        w_cap_buf = r_buf;
        w_wbyte   = r_wdata[7:0];
        case (r_cnt)
            3'd1:    w_cap_buf[7:0]   = bus.mem_din;
            3'd2:    w_cap_buf[15:8]  = bus.mem_din;
            3'd3:    w_cap_buf[23:16] = bus.mem_din;
            3'd4:    w_cap_buf[31:24] = bus.mem_din;
            default: w_cap_buf = r_buf;
        endcase
        case (r_cnt[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    // Next state, datapath and next registered outputs
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_nbytes   = r_nbytes;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_buf      = r_buf;
        w_last_ls  = r_last_ls;
        w_ic_valid = 1'b0;
        w_ic_data  = r_ic_data;
        w_ls_done  = 1'b0;
        w_ls_rdata = r_ls_rdata;
        w_mem_a    = '0;
        w_mem_dout = '0;
        w_mem_wr   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_ls_win) begin
                    w_state   = bus.ls_wr ? S_STORE : S_LOAD;
                    w_addr    = bus.ls_addr;
                    w_wdata   = bus.ls_wdata;
                    w_nbytes  = w_req_nbytes;
                    w_cnt     = '0;
                    w_buf     = '0;
                    w_last_ls = 1'b1;
                end else if (w_ic_ok) begin
                    w_state   = S_IFETCH;
                    w_addr    = bus.ic_addr;
                    w_nbytes  = CW'(4);
                    w_cnt     = '0;
                    w_buf     = '0;
                    w_last_ls = 1'b0;
                end
            end

            S_IFETCH, S_LOAD: begin
                if (r_state == S_IFETCH && bus.clr) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end else begin
                    if (r_cnt < r_nbytes) begin
                        w_mem_a = w_byte_a;
                    end
                    w_buf = w_cap_buf;
                    w_cnt = r_cnt + CW'(1);
                    if (r_cnt == r_nbytes) begin
                        w_state = S_IDLE;
                        if (r_state == S_IFETCH) begin
                            w_ic_valid = 1'b1;
                            w_ic_data  = w_cap_buf;
                        end else begin
                            w_ls_done  = 1'b1;
                            w_ls_rdata = w_cap_buf;
                        end
                    end
                end
            end

            S_STORE: begin
                if (!w_stall) begin
                    w_mem_a    = w_byte_a;
                    w_mem_dout = w_wbyte;
                    w_mem_wr   = 1'b1;
                    w_cnt      = r_cnt + CW'(1);
                    if (r_cnt == (r_nbytes - CW'(1))) begin
                        w_state   = S_IDLE;
                        w_ls_done = 1'b1;
                    end
                end
            end

            default: w_state = S_IDLE;
        endcase
    end

    // State, datapath and output registers; rdy low freezes all of them
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_nbytes   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_last_ls  <= 1'b0;
            r_ic_valid <= 1'b0;
            r_ic_data  <= '0;
            r_ls_done  <= 1'b0;
            r_ls_rdata <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
        end else if (rdy) begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_nbytes   <= w_nbytes;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_buf      <= w_buf;
            r_last_ls  <= w_last_ls;
            r_ic_valid <= w_ic_valid;
            r_ic_data  <= w_ic_data;
            r_ls_done  <= w_ls_done;
            r_ls_rdata <= w_ls_rdata;
            r_mem_a    <= w_mem_a;
            r_mem_dout <= w_mem_dout;
            r_mem_wr   <= w_mem_wr;
        end
    end

    assign bus.ic_valid = r_ic_valid;
    assign bus.ic_data  = r_ic_data;
    assign bus.ls_done  = r_ls_done;
    assign bus.ls_rdata = r_ls_rdata;
    assign bus.mem_a    = r_mem_a;
    assign bus.mem_dout = r_mem_dout;
    assign bus.mem_wr   = r_mem_wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, byte sequencing, clr, rdy, reset and I/O stall.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    logic rdy;

    mem_arbiter_if bus();

    mem_arbiter #(.IO_SEL(2'b11)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy    (rdy),
        .bus    (bus)
    );

    // RAM: preloaded read image, separate write record
    logic [7:0]  rom     [0:65535];
    logic [7:0]  wmem    [0:65535];
    int unsigned wr_cnt  [0:65535];

    assign bus.mem_din = rom[bus.mem_a[15:0]];

    always @(posedge clk) begin
        if (bus.mem_wr) begin
            wmem[bus.mem_a[15:0]]   <= bus.mem_dout;
            wr_cnt[bus.mem_a[15:0]] <= wr_cnt[bus.mem_a[15:0]] + 1;
        end
    end

    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  nresp;
    int  raises;
    bit  resp_ls  [8];
    int  resp_cyc [8];
    bit  exp_ls   [6];
    int  exp_cyc  [6];

    initial begin
        clk = 1'b0; rst = 1'b1; rdy = 1'b1;
        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_addr = '0; bus.ls_size = 2'b00; bus.ls_wdata = '0;
        bus.clr = 1'b0; bus.io_buffer_full = 1'b0;
        n_chk = 0; n_fail = 0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        rom[16'h0100] = 8'h13; rom[16'h0101] = 8'h00; rom[16'h0102] = 8'h00; rom[16'h0103] = 8'h00;
        rom[16'h0200] = 8'hAA; rom[16'h0201] = 8'hBB; rom[16'h0202] = 8'hCC; rom[16'h0203] = 8'hDD;
        rom[16'h0400] = 8'h11; rom[16'h0401] = 8'h22; rom[16'h0402] = 8'h33; rom[16'h0403] = 8'h44;
        rom[16'h0404] = 8'h55;
        rom[16'hFFFF] = 8'h81; rom[16'h0000] = 8'h7E;
        exp_ls[0] = 1'b1; exp_ls[1] = 1'b0; exp_ls[2] = 1'b1;
        exp_ls[3] = 1'b0; exp_ls[4] = 1'b1; exp_ls[5] = 1'b0;
        exp_cyc[0] = 6;  exp_cyc[1] = 12; exp_cyc[2] = 18;
        exp_cyc[3] = 24; exp_cyc[4] = 30; exp_cyc[5] = 36;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_ic_valid", 32'(bus.ic_valid), 32'd0);
        chk("rst_ic_data",  bus.ic_data, 32'd0);
        chk("rst_ls_done",  32'(bus.ls_done), 32'd0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
        chk("rst_mem_a",    bus.mem_a, 32'd0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst_mem_wr",   32'(bus.mem_wr), 32'd0);

        // Fetch from 0x100: four addresses, valid five cycles after accept
        bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
        tick();
        chk("fetch_e0_mem_a", bus.mem_a, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fetch_mem_a", bus.mem_a, 32'h100 + 32'(k));
            chk("fetch_no_valid", 32'(bus.ic_valid), 32'd0);
            chk("fetch_mem_wr", 32'(bus.mem_wr), 32'd0);
        end
        tick();
        chk("fetch_valid", 32'(bus.ic_valid), 32'd1);
        chk("fetch_data", bus.ic_data, 32'h0000_0013);
        chk("fetch_idle_mem_a", bus.mem_a, 32'd0);
        bus.ic_req = 1'b0;
        tick();
        chk("fetch_valid_pulse", 32'(bus.ic_valid), 32'd0);

        // Alternating grants with both requests raised together three times
        bus.ls_wr = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h400; bus.ic_addr = 32'h100;
        bus.ic_req = 1'b1; bus.ls_req = 1'b1;
        raises = 1; nresp = 0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            chk("alt_exclusive", 32'(bus.ic_valid & bus.ls_done), 32'd0);
            if (bus.ls_done) begin
                if (nresp < 8) begin resp_ls[nresp] = 1'b1; resp_cyc[nresp] = c; end
                nresp++;
                chk("alt_ls_rdata", bus.ls_rdata, 32'h4433_2211);
                bus.ls_req = 1'b0;
            end
            if (bus.ic_valid) begin
                if (nresp < 8) begin resp_ls[nresp] = 1'b0; resp_cyc[nresp] = c; end
                nresp++;
                chk("alt_ic_data", bus.ic_data, 32'h0000_0013);
                bus.ic_req = 1'b0;
            end
            if (!bus.ic_req && !bus.ls_req && raises < 3) begin
                bus.ic_req = 1'b1; bus.ls_req = 1'b1;
                raises++;
            end
        end
        chk("alt_nresp", 32'(nresp), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("alt_order", 32'(resp_ls[i]), 32'(exp_ls[i]));
            chk("alt_cycle", 32'(resp_cyc[i]), 32'(exp_cyc[i]));
        end

        // Half-word store to 0x2000
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b01;
        bus.ls_addr = 32'h2000; bus.ls_wdata = 32'hABCD_1234;
        tick();
        chk("st_e0_mem_wr", 32'(bus.mem_wr), 32'd0);
        tick();
        chk("st_b0_wr",   32'(bus.mem_wr), 32'd1);
        chk("st_b0_a",    bus.mem_a, 32'h2000);
        chk("st_b0_dout", 32'(bus.mem_dout), 32'h34);
        chk("st_b0_done", 32'(bus.ls_done), 32'd0);
        tick();
        chk("st_b1_wr",   32'(bus.mem_wr), 32'd1);
        chk("st_b1_a",    bus.mem_a, 32'h2001);
        chk("st_b1_dout", 32'(bus.mem_dout), 32'h12);
        chk("st_b1_done", 32'(bus.ls_done), 32'd1);
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0;
        tick();
        chk("st_end_wr",   32'(bus.mem_wr), 32'd0);
        chk("st_end_done", 32'(bus.ls_done), 32'd0);
        chk("st_end_a",    bus.mem_a, 32'd0);
        chk("st_end_dout", 32'(bus.mem_dout), 32'd0);
        chk("st_ram_2000", 32'(wmem[16'h2000]), 32'h34);
        chk("st_ram_2001", 32'(wmem[16'h2001]), 32'h12);
        chk("st_cnt_2000", 32'(wr_cnt[16'h2000]), 32'd1);
        chk("st_cnt_2002", 32'(wr_cnt[16'h2002]), 32'd0);

        // clr aborts a fetch after two bytes, then blocks the grant while still high in IDLE
        bus.ic_req = 1'b1; bus.ic_addr = 32'h200;
        tick();
        tick();
        chk("clr_b0_a", bus.mem_a, 32'h200);
        tick();
        chk("clr_b1_a", bus.mem_a, 32'h201);
        bus.clr = 1'b1;
        tick();
        chk("clr_abort_a",     bus.mem_a, 32'd0);
        chk("clr_abort_valid", 32'(bus.ic_valid), 32'd0);
        bus.ic_addr = 32'h100;
        tick();
        chk("clr_block_a",     bus.mem_a, 32'd0);
        chk("clr_block_valid", 32'(bus.ic_valid), 32'd0);
        bus.clr = 1'b0;
        tick();
        chk("clr_accept_a", bus.mem_a, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("clr_refetch_a", bus.mem_a, 32'h100 + 32'(k));
            chk("clr_refetch_no_valid", 32'(bus.ic_valid), 32'd0);
        end
        tick();
        chk("clr_refetch_valid", 32'(bus.ic_valid), 32'd1);
        chk("clr_refetch_data",  bus.ic_data, 32'h0000_0013);
        bus.ic_req = 1'b0;
        tick();

        // rdy low for three cycles in the middle of a word load from 0x401
        bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'b10; bus.ls_addr = 32'h401;
        tick();
        tick();
        chk("rdy_b0_a", bus.mem_a, 32'h401);
        tick();
        chk("rdy_b1_a", bus.mem_a, 32'h402);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rdy_frozen_a",    bus.mem_a, 32'h402);
            chk("rdy_frozen_done", 32'(bus.ls_done), 32'd0);
        end
        rdy = 1'b1;
        tick();
        chk("rdy_b2_a", bus.mem_a, 32'h403);
        tick();
        chk("rdy_b3_a", bus.mem_a, 32'h404);
        tick();
        chk("rdy_done",  32'(bus.ls_done), 32'd1);
        chk("rdy_rdata", bus.ls_rdata, 32'h5544_3322);
        chk("rdy_end_a", bus.mem_a, 32'd0);
        bus.ls_req = 1'b0;
        tick();

        // Reset during a word store, with rdy low on the reset edge
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b10;
        bus.ls_addr = 32'h2100; bus.ls_wdata = 32'h5566_7788;
        tick();
        tick();
        chk("rst_st_b0_dout", 32'(bus.mem_dout), 32'h88);
        tick();
        chk("rst_st_b1_a", bus.mem_a, 32'h2101);
        rst = 1'b1; rdy = 1'b0;
        tick();
        chk("mid_rst_ic_valid", 32'(bus.ic_valid), 32'd0);
        chk("mid_rst_ic_data",  bus.ic_data, 32'd0);
        chk("mid_rst_ls_done",  32'(bus.ls_done), 32'd0);
        chk("mid_rst_ls_rdata", bus.ls_rdata, 32'd0);
        chk("mid_rst_mem_a",    bus.mem_a, 32'd0);
        chk("mid_rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("mid_rst_mem_wr",   32'(bus.mem_wr), 32'd0);
        rst = 1'b0; rdy = 1'b1; bus.ls_req = 1'b0; bus.ls_wr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("post_rst_done", 32'(bus.ls_done), 32'd0);
            chk("post_rst_wr",   32'(bus.mem_wr), 32'd0);
        end
        chk("rst_cnt_2101", 32'(wr_cnt[16'h2101]), 32'd1);
        chk("rst_cnt_2102", 32'(wr_cnt[16'h2102]), 32'd0);

        // One-byte store to the I/O region while the UART buffer is full
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b00;
        bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 32'h0000_005A;
        bus.io_buffer_full = 1'b1;
        tick();
        chk("io_e0_wr", 32'(bus.mem_wr), 32'd0);
`ifdef MEM_ARB_IO_STALL_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("io_stall_wr",   32'(bus.mem_wr), 32'd0);
            chk("io_stall_done", 32'(bus.ls_done), 32'd0);
        end
        bus.io_buffer_full = 1'b0;
        tick();
`else
        tick();
`endif
        chk("io_wr",   32'(bus.mem_wr), 32'd1);
        chk("io_a",    bus.mem_a, 32'h0003_0000);
        chk("io_dout", 32'(bus.mem_dout), 32'h5A);
        chk("io_done", 32'(bus.ls_done), 32'd1);
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0;
        tick();
        chk("io_end_wr", 32'(bus.mem_wr), 32'd0);
        bus.io_buffer_full = 1'b0;
        tick();
        chk("io_write_count", 32'(wr_cnt[16'h0000]), 32'd1);

        // Half-word load across the 32-bit address wrap
        bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'b01; bus.ls_addr = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("wrap_b0_a", bus.mem_a, 32'hFFFF_FFFF);
        tick();
        chk("wrap_b1_a", bus.mem_a, 32'h0000_0000);
        tick();
        chk("wrap_done",  32'(bus.ls_done), 32'd1);
        chk("wrap_rdata", bus.ls_rdata, 32'h0000_7E81);
        bus.ls_req = 1'b0;
        tick();
        chk("wrap_done_pulse", 32'(bus.ls_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
